// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// default boot address, PC step and instruction word width.
package instr_fetch_unit_pkg;

   localparam int          WORD_WIDTH       = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register for the fetch stage. Loads the boot address on
// reset, a redirect target on branch/jump, or steps by one word on advance.
// With FETCH_CHECK_EN defined, redirect targets are word-aligned and a
// misaligned target is flagged to the parent.
module instr_fetch_unit_pc_reg
   import instr_fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = WORD_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC[DATA_WIDTH-1:0]
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  advance,
`ifdef FETCH_CHECK_EN
   output logic                  misaligned,
`endif
   output logic [DATA_WIDTH-1:0] pc
);

   logic [DATA_WIDTH-1:0] target;

   // Select the value a redirect loads; alignment is forced only when checks are on
   always_comb begin
      target = redirect_pc;
`ifdef FETCH_CHECK_EN
      target     = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      misaligned = |redirect_pc[1:0];
`endif
   end

   // PC update: reset beats redirect, redirect beats sequential advance
   always_ff @(posedge clk) begin
      if (!rst_n)
         pc <= RESET_PC;
      else if (redirect)
         pc <= target;
      else if (advance)
         pc <= pc + DATA_WIDTH'(PC_INC);
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: drives the ROM address from the PC, captures the
// returned word into the IF/ID register and handshakes with decode.
// Optional FETCH_CHECK_EN adds a sticky fetch-address error flag.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH   = WORD_WIDTH,
   parameter int                    MEMORY_DEPTH = 64,
   parameter logic [DATA_WIDTH-1:0] RESET_PC     = DEFAULT_RESET_PC[DATA_WIDTH-1:0]
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [DATA_WIDTH-1:0] Address_o,
   input  logic [DATA_WIDTH-1:0] Instruction_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] Instruction_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic [DATA_WIDTH-1:0] pc_plus4_o,
   output logic [31:0]           fetch_count_o,
   output logic                  err_o
);

   fetch_state_t          state;
   fetch_state_t          state_next;
   logic                  capture;
   logic                  handshake;
   logic [DATA_WIDTH-1:0] pc;
`ifdef FETCH_CHECK_EN
   logic                  misaligned;
`endif

   instr_fetch_unit_pc_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect_i),
      .redirect_pc (redirect_pc_i),
      .advance     (capture),
`ifdef FETCH_CHECK_EN
      .misaligned  (misaligned),
`endif
      .pc          (pc)
   );

   assign Address_o = pc;
   assign valid_o   = (state != S_BOOT);
   assign handshake = valid_o & ready_i;

   // State register for the boot/run/hold handshake machine
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= S_BOOT;
      else
         state <= state_next;
   end

   // Next state and capture decision; a redirect discards any capture and reboots
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         S_BOOT: begin
            capture    = 1'b1;
            state_next = S_RUN;
         end
         S_RUN: begin
            if (ready_i)
               capture = 1'b1;
            else
               state_next = S_HOLD;
         end
         S_HOLD: begin
            if (ready_i) begin
               capture    = 1'b1;
               state_next = S_RUN;
            end
         end
         default: state_next = S_BOOT;
      endcase
      if (redirect_i) begin
         capture    = 1'b0;
         state_next = S_BOOT;
      end
   end

   // IF/ID output register, loaded with the ROM word and its address on capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Instruction_o <= '0;
         pc_o          <= '0;
         pc_plus4_o    <= '0;
      end else if (capture) begin
         Instruction_o <= Instruction_i;
         pc_o          <= pc;
         pc_plus4_o    <= pc + DATA_WIDTH'(PC_INC);
      end
   end

   // Count every accepted word, including one accepted in a redirect cycle
   always_ff @(posedge clk) begin
      if (!rst_n)
         fetch_count_o <= '0;
      else if (handshake)
         fetch_count_o <= fetch_count_o + 32'd1;
   end

`ifdef FETCH_CHECK_EN
   localparam logic [DATA_WIDTH-1:0] PC_LIMIT = RESET_PC + DATA_WIDTH'(4 * MEMORY_DEPTH);

   logic out_of_range;
   logic err_set;

   assign out_of_range = (pc < RESET_PC) || (pc >= PC_LIMIT);
   assign err_set      = (redirect_i & misaligned) | (capture & out_of_range);

   // Sticky error flag; fetching carries on regardless
   always_ff @(posedge clk) begin
      if (!rst_n)
         err_o <= 1'b0;
      else if (err_set)
         err_o <= 1'b1;
   end
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a per-cycle vector table for the scripted
// corner cases, a free-running section for the address-range error, and a
// stream scoreboard that checks every accepted word against a ROM model.
// Expectations follow FETCH_CHECK_EN when it is defined for the build.
module tb_instr_fetch_unit;

   localparam logic [31:0] R = 32'h0040_0000;

`ifdef FETCH_CHECK_EN
   localparam logic [31:0] MIS     = R + 32'h4;
   localparam logic        ERR_ON  = 1'b1;
`else
   localparam logic [31:0] MIS     = R + 32'h6;
   localparam logic        ERR_ON  = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic        red;
      logic [31:0] rpc;
      logic        rdy;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] count;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] Address_o;
   logic [31:0] Instruction_i;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        ready_i = 1'b0;
   logic        valid_o;
   logic [31:0] Instruction_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic [31:0] fetch_count_o;
   logic        err_o;

   int          assertCount = 0;
   int          failCount   = 0;
   int          hsCount     = 0;
   logic [31:0] expQ[$];
   vec_t        vecs[18];

   instr_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .Address_o     (Address_o),
      .Instruction_i (Instruction_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .ready_i       (ready_i),
      .valid_o       (valid_o),
      .Instruction_o (Instruction_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o),
      .fetch_count_o (fetch_count_o),
      .err_o         (err_o)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Combinational ROM model: a scrambled function of the byte address
   function automatic logic [31:0] romWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign Instruction_i = romWord(Address_o);

   function automatic vec_t mk(input logic rst, input logic red, input logic [31:0] rpc,
                               input logic rdy, input logic [31:0] addr, input logic valid,
                               input logic [31:0] pc, input logic [31:0] count, input logic err);
      vec_t v;
      v.rst = rst; v.red = red; v.rpc = rpc; v.rdy = rdy;
      v.addr = addr; v.valid = valid; v.pc = pc; v.count = count; v.err = err;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Restart the expected fetch stream from a new start address
   task automatic reloadStream(input logic [31:0] base);
      expQ.delete();
      for (int i = 0; i < 128; i++)
         expQ.push_back(base + 32'(4 * i));
   endtask

   // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later
   task automatic applyStimulus(input logic rst, input logic red, input logic [31:0] rpc, input logic rdy);
      rst_n         = rst;
      redirect_i    = red;
      redirect_pc_i = rpc;
      ready_i       = rdy;
      @(posedge clk);
      if (!rst) begin
         reloadStream(R);
         hsCount = 0;
      end else if (red) begin
`ifdef FETCH_CHECK_EN
         reloadStream({rpc[31:2], 2'b00});
`else
         reloadStream(rpc);
`endif
      end
      #1;
   endtask

   // Scoreboard: on every accepted word, pop the expected address and check the word
   always @(negedge clk) begin
      if (rst_n && valid_o && ready_i) begin
         hsCount++;
         if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL sb_empty: got handshake with pc_o 0x%08h, expected no handshake", pc_o);
         end else begin
            logic [31:0] e;
            e = expQ.pop_front();
            checkOutput("sb_pc", pc_o, e);
            checkOutput("sb_instr", Instruction_o, romWord(e));
            checkOutput("sb_pc4", pc_plus4_o, e + 32'd4);
         end
      end
   end

   initial begin
      vecs[0]  = mk(0, 0, 0,        1, R,           0, 0,          0, 0);
      vecs[1]  = mk(0, 0, 0,        1, R,           0, 0,          0, 0);
      vecs[2]  = mk(1, 0, 0,        1, R + 32'h04,  1, R,          0, 0);
      vecs[3]  = mk(1, 0, 0,        1, R + 32'h08,  1, R + 32'h04, 1, 0);
      vecs[4]  = mk(1, 0, 0,        1, R + 32'h0C,  1, R + 32'h08, 2, 0);
      vecs[5]  = mk(1, 0, 0,        0, R + 32'h0C,  1, R + 32'h08, 2, 0);
      vecs[6]  = mk(1, 0, 0,        0, R + 32'h0C,  1, R + 32'h08, 2, 0);
      vecs[7]  = mk(1, 0, 0,        0, R + 32'h0C,  1, R + 32'h08, 2, 0);
      vecs[8]  = mk(1, 0, 0,        1, R + 32'h10,  1, R + 32'h0C, 3, 0);
      vecs[9]  = mk(1, 0, 0,        0, R + 32'h10,  1, R + 32'h0C, 3, 0);
      vecs[10] = mk(1, 1, R + 32'h10, 0, R + 32'h10, 0, R + 32'h0C, 3, 0);
      vecs[11] = mk(1, 0, 0,        1, R + 32'h14,  1, R + 32'h10, 3, 0);
      vecs[12] = mk(1, 0, 0,        1, R + 32'h18,  1, R + 32'h14, 4, 0);
      vecs[13] = mk(1, 0, 0,        1, R + 32'h1C,  1, R + 32'h18, 5, 0);
      vecs[14] = mk(0, 1, R + 32'h40, 1, R,         0, 0,          0, 0);
      vecs[15] = mk(1, 0, 0,        1, R + 32'h04,  1, R,          0, 0);
      vecs[16] = mk(1, 1, R + 32'h06, 1, MIS,       0, R,          1, ERR_ON);
      vecs[17] = mk(1, 0, 0,        1, MIS + 32'h4, 1, MIS,        1, ERR_ON);

      $display("[TB] scripted vector sequence");
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].red, vecs[i].rpc, vecs[i].rdy);
         checkOutput($sformatf("v%0d_addr", i),  Address_o, vecs[i].addr);
         checkOutput($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vecs[i].valid));
         checkOutput($sformatf("v%0d_pc", i),    pc_o, vecs[i].pc);
         checkOutput($sformatf("v%0d_pc4", i),   pc_plus4_o,
                     (vecs[i].pc == 0) ? 32'h0 : vecs[i].pc + 32'd4);
         checkOutput($sformatf("v%0d_instr", i), Instruction_o,
                     (vecs[i].pc == 0) ? 32'h0 : romWord(vecs[i].pc));
         checkOutput($sformatf("v%0d_count", i), fetch_count_o, vecs[i].count);
         checkOutput($sformatf("v%0d_err", i),   32'(err_o), 32'(vecs[i].err));
      end

      $display("[TB] free run past the end of the ROM");
      applyStimulus(0, 0, 0, 1);
      checkOutput("fr_reset_err", 32'(err_o), 32'h0);
      checkOutput("fr_reset_count", fetch_count_o, 32'h0);
      for (int n = 1; n <= 70; n++) begin
         applyStimulus(1, 0, 0, 1);
         checkOutput($sformatf("fr%0d_err", n), 32'(err_o),
                     32'(ERR_ON && (n >= 65)));
      end
      checkOutput("fr_addr", Address_o, R + 32'(4 * 70));
      checkOutput("fr_count_const", fetch_count_o, 32'd69);
      checkOutput("fr_count_sb", fetch_count_o, 32'(hsCount));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
